seg7_scan_driver: RTL

Parametrised multiplexed seven-segment driver. It time-multiplexes `DIGITS` hex digits onto shared active-low segment lines and drives one-cold digit anodes. It adds three behaviours to the fixed four-digit strober:

- tear-free shadow loading with a LOAD/LOAD_ACK handshake;
- per-digit decimal points and leading-zero blanking;
- optional brightness PWM.

It sits between the mouse-status logic and the board display pins.

---
 rtl/seg7_pkg.sv | 24 ++
 rtl/seg7_glyph_decode.sv | 21 ++
 rtl/seg7_scan_driver.sv | 130 +++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment driver.
// Contents: 16-entry active-low hex glyph table {dp,g,f,e,d,c,b,a} with dp off,
// DP_OFF / BLANK patterns, and the nibble-to-segment decode function.
package seg7_pkg;

  localparam logic [7:0] DP_OFF = 8'hFF;
  localparam logic [7:0] BLANK  = 8'hFF;

  // Index 15 is leftmost in the concatenation, index 0 rightmost.
  localparam logic [15:0][7:0] GLYPH_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6,   // F E D C
    8'h83, 8'h88, 8'h90, 8'h80,   // B A 9 8
    8'hF8, 8'h82, 8'h92, 8'h99,   // 7 6 5 4
    8'hB0, 8'hA4, 8'hF9, 8'hC0    // 3 2 1 0
  };

  // Glyph for a nibble with the decimal point forced off.
  function automatic logic [7:0] seg_decode(input logic [3:0] nib);
    logic [7:0] glyph;
    glyph = GLYPH_TABLE[nib];
    return {DP_OFF[7], glyph[6:0]};
  endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational digit pattern generator.
// Ports: nib (hex nibble), dot (decimal point request, active-high),
//        blank (force all segments off), seg_c (active-low {dp,g..a}).
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       dot,
  input  logic       blank,
  output logic [7:0] seg_c
);

  always_comb begin
    seg_c = BLANK;
    if (!blank) begin
      seg_c = seg_decode(nib);
      if (dot) seg_c[7] = 1'b0;
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver with tear-free shadow loading,
// per-digit decimal points, leading-zero blanking and optional brightness PWM.
// Ports: CLK, RESET_N (async active-low), VALUE_IN/DOT_IN/LOAD (staging write),
//        BLANK_LZ (live), BRIGHTNESS (PWM on-time), LOAD_ACK, FRAME_TICK,
//        HEX_OUT (active-low segments), SEG_SELECT (active-low anodes).
// Build option: define SEG_PWM_EN to gate the active anode with a PWM counter.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned CLK_DIV  = 100000,
  parameter int unsigned PWM_BITS = 4
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic [4*DIGITS-1:0]   VALUE_IN,
  input  logic [DIGITS-1:0]     DOT_IN,
  input  logic                  LOAD,
  input  logic                  BLANK_LZ,
  input  logic [PWM_BITS-1:0]   BRIGHTNESS,
  output logic                  LOAD_ACK,
  output logic                  FRAME_TICK,
  output logic [7:0]            HEX_OUT,
  output logic [DIGITS-1:0]     SEG_SELECT
);

  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned VW = 4 * DIGITS;

  logic [PW-1:0]     presc;
  logic [IW-1:0]     index;
  logic [VW-1:0]     stage_value;
  logic [DIGITS-1:0] stage_dot;
  logic [VW-1:0]     disp_value;
  logic [DIGITS-1:0] disp_dot;
  logic              pending;

  logic              terminal_c;
  logic              last_c;
  logic              boundary_c;
  logic              pwm_on_c;
  logic [3:0]        cur_nib_c;
  logic              cur_dot_c;
  logic              cur_blank_c;
  logic [DIGITS-1:0] anode_c;
  logic [7:0]        seg_c;

  assign terminal_c = (presc == PW'(CLK_DIV - 1));
  assign last_c     = (index == IW'(DIGITS - 1));
  assign boundary_c = terminal_c && last_c;

`ifdef SEG_PWM_EN
  // Free-running brightness counter; anode enabled while counter <= BRIGHTNESS.
  logic [PWM_BITS-1:0] pwm_cnt;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) pwm_cnt <= '0;
    else          pwm_cnt <= PWM_BITS'(pwm_cnt + 1'b1);
  end

  assign pwm_on_c = (pwm_cnt <= BRIGHTNESS);
`else
  logic unused_brightness;
  assign unused_brightness = ^BRIGHTNESS;
  assign pwm_on_c = 1'b1;
`endif

  // Select the current digit and evaluate leading-zero blanking from the top down.
  always_comb begin
    logic zero_above;
    cur_nib_c   = 4'h0;
    cur_dot_c   = 1'b0;
    cur_blank_c = 1'b0;
    anode_c     = '1;
    zero_above  = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      zero_above = zero_above && (disp_value[4*i +: 4] == 4'h0) && !disp_dot[i];
      if (IW'(i) == index) begin
        cur_nib_c   = disp_value[4*i +: 4];
        cur_dot_c   = disp_dot[i];
        cur_blank_c = BLANK_LZ && (i != 0) && zero_above;
        anode_c[i]  = cur_blank_c || !pwm_on_c;
      end
    end
  end

  seg7_glyph_decode u_decode (
    .nib   (cur_nib_c),
    .dot   (cur_dot_c),
    .blank (cur_blank_c),
    .seg_c (seg_c)
  );

  // Scan timing, shadow registers and registered outputs.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      presc       <= '0;
      index       <= '0;
      stage_value <= '0;
      stage_dot   <= '0;
      disp_value  <= '0;
      disp_dot    <= '0;
      pending     <= 1'b0;
      LOAD_ACK    <= 1'b0;
      FRAME_TICK  <= 1'b0;
      HEX_OUT     <= BLANK;
      SEG_SELECT  <= '1;
    end else begin
      presc <= terminal_c ? '0 : PW'(presc + 1'b1);
      if (terminal_c) index <= last_c ? '0 : IW'(index + 1'b1);

      if (LOAD) begin
        stage_value <= VALUE_IN;
        stage_dot   <= DOT_IN;
      end
      // A boundary commits what was staged before this cycle's LOAD.
      if (boundary_c && pending) begin
        disp_value <= stage_value;
        disp_dot   <= stage_dot;
      end
      pending    <= LOAD || (pending && !boundary_c);
      LOAD_ACK   <= boundary_c && pending;
      FRAME_TICK <= boundary_c;
      HEX_OUT    <= seg_c;
      SEG_SELECT <= anode_c;
    end
  end

endmodule
